// File: rtl/divisor_seq_if.sv
// Start/done handshake and hi/lo result bus of the sequential divider.
// The requester drives the operands and the start pulse. The divider returns done, the flags and the results.
interface divisor_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             DivIn;
    logic             DivOut;
    logic             Busy;
    logic             DivZero;
    logic [WIDTH-1:0] resultHigh;
    logic [WIDTH-1:0] resultLow;

    modport master (
        output A, B, DivIn,
        input  DivOut, Busy, DivZero, resultHigh, resultLow
    );

    modport slave (
        input  A, B, DivIn,
        output DivOut, Busy, DivZero, resultHigh, resultLow
    );
endinterface

// File: rtl/divisor_seq.sv
// Sequential signed divider: a restoring loop on magnitudes (one quotient bit per cycle), then a sign fix-up.
// Defining DIVISOR_ZERO_TRAP_EN makes a zero divisor finish after one cycle with DivZero set.
module divisor_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          Reset,
    divisor_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic             sign_a;
    logic             sign_b;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
`ifdef DIVISOR_ZERO_TRAP_EN
    logic             div_zero;
    logic             zero_pending;
`endif

    // Magnitudes are unsigned WIDTH bits, so the most negative value maps onto itself.
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    assign abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;

    // NOTE: every variable written in always_comb gets a default first; otherwise a latch is inferred.
    always_comb begin
        shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        fits     = 1'b0;
        rem_next = shifted;
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, divisor}) begin
            fits     = 1'b1;
            rem_next = shifted - {1'b0, divisor};
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    // NOTE: the datapath registers are reset too, because all outputs and internal state must read zero after an abort.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            count   <= '0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            res_hi  <= '0;
            res_lo  <= '0;
`ifdef DIVISOR_ZERO_TRAP_EN
            div_zero     <= 1'b0;
            zero_pending <= 1'b0;
`endif
        end else if (bus.DivIn) begin
            // A start in any state silently abandons whatever was in flight.
            divisor <= abs_b;
            quo     <= abs_a;
            rem     <= '0;
            sign_a  <= bus.A[WIDTH-1];
            sign_b  <= bus.B[WIDTH-1];
            count   <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef DIVISOR_ZERO_TRAP_EN
            div_zero     <= 1'b0;
            zero_pending <= (bus.B == '0);
            state        <= (bus.B == '0) ? FIX : RUN;
`else
            state   <= RUN;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    done  <= 1'b1;
                    state <= DONE;
`ifdef DIVISOR_ZERO_TRAP_EN
                    if (zero_pending) begin
                        div_zero <= 1'b1;
                    end else begin
                        res_lo <= (sign_a ^ sign_b) ? -quo : quo;
                        res_hi <= sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end
`else
                    res_lo <= (sign_a ^ sign_b) ? -quo : quo;
                    res_hi <= sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`endif
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef DIVISOR_ZERO_TRAP_EN
                    div_zero <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.DivOut     = done;
    assign bus.Busy       = busy;
    assign bus.resultHigh = res_hi;
    assign bus.resultLow  = res_lo;
`ifdef DIVISOR_ZERO_TRAP_EN
    assign bus.DivZero    = div_zero;
`else
    assign bus.DivZero    = 1'b0;
`endif

    // The done pulse is one cycle wide, it always falls inside Busy, and DivZero only appears alongside it.
    a_done_in_busy : assert property (@(posedge clk) disable iff (Reset) bus.DivOut |-> bus.Busy);
    a_done_pulse   : assert property (@(posedge clk) disable iff (Reset) bus.DivOut |=> !bus.DivOut);
    a_zero_on_done : assert property (@(posedge clk) disable iff (Reset) bus.DivZero |-> bus.DivOut);

endmodule

// File: tb/tb_divisor_seq.sv
// Bench for divisor_seq: a scoreboard of expected quotient/remainder/flag/latency,
// filled when a start is driven and drained when DivOut is seen.
module tb_divisor_seq;
    logic clk;
    logic Reset;
    int   cycle;
    int   checks;
    int   errors;

    divisor_seq_if #(.WIDTH(32)) bus ();

    divisor_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        logic        keep;
        int          lat;
        int          start;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_lo;
    logic [31:0] last_hi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.keep  = 1'b0;
        e.dz    = 1'b0;
        e.lat   = 33;
        e.start = 0;
        e.lo    = '0;
        e.hi    = '0;
        if (b == 32'h0) begin
`ifdef DIVISOR_ZERO_TRAP_EN
            e.keep = 1'b1;
            e.dz   = 1'b1;
            e.lat  = 1;
`else
            e.lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
            e.hi = a;
`endif
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'h0;
        end else begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
        end
        return e;
    endfunction

    // Output monitor: every DivOut must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.DivOut === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_divout", bus.DivOut, 1'b0);
            end else begin
                exp_t e;
                logic [31:0] want_lo;
                logic [31:0] want_hi;
                e = sb.pop_front();
                want_lo = e.keep ? last_lo : e.lo;
                want_hi = e.keep ? last_hi : e.hi;
                check("result_low", bus.resultLow, want_lo);
                check("result_high", bus.resultHigh, want_hi);
                check("div_zero", bus.DivZero, e.dz);
                check("latency", cycle - e.start, e.lat);
                last_lo = want_lo;
                last_hi = want_hi;
            end
        end
    end

    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        sb.delete();
        bus.A     = a;
        bus.B     = b;
        bus.DivIn = 1'b1;
        e         = model(a, b);
        e.start   = cycle + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.DivIn = 1'b0;
        check("busy_after_start", bus.Busy, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b);
        start_div(a, b);
        wait_idle();
        @(negedge clk);
        check("busy_after_done", bus.Busy, 1'b0);
        check("divout_one_cycle", bus.DivOut, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        last_lo   = '0;
        last_hi   = '0;
        bus.A     = '0;
        bus.B     = '0;
        bus.DivIn = 1'b0;
        Reset     = 1'b0;
        #1 Reset  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_divout", bus.DivOut, 1'b0);
        check("rst_busy", bus.Busy, 1'b0);
        check("rst_divzero", bus.DivZero, 1'b0);
        check("rst_lo", bus.resultLow, 32'h0);
        check("rst_hi", bus.resultHigh, 32'h0);
        Reset = 1'b0;

        run_div(32'd100, 32'd7);
        repeat (5) @(negedge clk);
        check("hold_lo", bus.resultLow, 32'd14);
        check("hold_hi", bus.resultHigh, 32'd2);

        run_div(-32'd100, 32'd7);
        run_div(32'd100, -32'd7);
        run_div(32'd7, 32'd0);
        run_div(-32'd7, 32'd0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF);
        run_div(32'd5, 32'd9);
        run_div(32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            rb = $urandom() >> $urandom_range(0, 28);
            run_div(ra, rb);
        end

        // Restart mid-operation: only the second request may complete.
        start_div(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        start_div(32'd81, 32'd9);
        wait_idle();
        @(negedge clk);
        check("busy_after_restart", bus.Busy, 1'b0);

        // Reset mid-operation: everything clears at once and no DivOut follows.
        run_div(32'd50, 32'd3);
        start_div(32'd100, 32'd7);
        repeat (14) @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        check("abort_divout", bus.DivOut, 1'b0);
        check("abort_busy", bus.Busy, 1'b0);
        check("abort_lo", bus.resultLow, 32'h0);
        check("abort_hi", bus.resultHigh, 32'h0);
        sb.delete();
        last_lo = '0;
        last_hi = '0;
        @(negedge clk);
        Reset = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_after_abort", bus.Busy, 1'b0);

        run_div(32'd1000, -32'd33);
        run_div(32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
